// File: rtl/timer_bcd_decoder_pkg.sv
// Shared types and constants for the timer BCD decoder.
// The 7-segment table is consumed only when TIMER_SEG7_EN is defined.
package timer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int TIMER_WIDTH  = 16;
  localparam int TIMER_DIGITS = 5;

  // Active-high gfedcba patterns; codes 10..15 never occur and are blanked.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

endpackage

// File: rtl/timer_bcd_decoder_if.sv
// Timer-to-decoder link plus decoded digit outputs.
// The seg bundle exists only when TIMER_SEG7_EN is defined.
interface timer_bcd_decoder_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  t_valid;
  logic [WIDTH-1:0]      t_out;
  logic                  busy;
  logic                  d_valid;
  logic                  ovr;
  logic [4*DIGITS-1:0]   digits;
`ifdef TIMER_SEG7_EN
  logic [7*DIGITS-1:0]   seg;
`endif

  modport master (
    output t_valid, t_out,
`ifdef TIMER_SEG7_EN
    input  seg,
`endif
    input  busy, d_valid, ovr, digits
  );

  modport slave (
    input  t_valid, t_out,
`ifdef TIMER_SEG7_EN
    output seg,
`endif
    output busy, d_valid, ovr, digits
  );
endinterface

// File: rtl/timer_bcd_decoder_seg7_decode.sv
// Combinational BCD nibble to active-high gfedcba segment pattern.
// Present only when TIMER_SEG7_EN is defined.
`ifdef TIMER_SEG7_EN
module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  assign o_seg = SEG7_LUT[i_bcd];
endmodule
`endif

// File: rtl/timer_bcd_decoder.sv
// Sequential double-dabble converter: binary timer count to DIGITS BCD digits.
// Optional TIMER_SEG7_EN adds a registered 7-segment output per digit.
module timer_bcd_decoder
  import timer_pkg::*;
#(
  parameter int WIDTH  = TIMER_WIDTH,
  parameter int DIGITS = TIMER_DIGITS
) (
  input  logic                 clock,
  input  logic                 reset,
  timer_bcd_decoder_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int BCD_W = 4 * DIGITS;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [WIDTH-1:0]         r_bin;
  logic [BCD_W-1:0]         r_bcd;
  logic [CNT_W-1:0]         r_cnt;
  logic [BCD_W-1:0]         r_digits;
  logic                     r_busy;
  logic                     r_dvalid;
  logic                     r_ovr;
  logic [BCD_W-1:0]         w_bcd_adj;
  logic [BCD_W+WIDTH-1:0]   w_cat;
  logic [BCD_W-1:0]         w_bcd_next;
  logic [WIDTH-1:0]         w_bin_next;
  logic                     w_done;

  // Add-3 on each nibble independently, then one left shift of the whole pair.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                 r_bcd[4*g +: 4] + 4'd3 : r_bcd[4*g +: 4];
  end

  assign w_cat      = {w_bcd_adj, r_bin} << 1;
  assign w_bcd_next = w_cat[BCD_W+WIDTH-1:WIDTH];
  assign w_bin_next = w_cat[WIDTH-1:0];
  assign w_done     = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.t_valid) w_next_state = SHIFT;
      SHIFT:   if (w_done)      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
      r_busy   <= 1'b0;
      r_dvalid <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_busy   <= (w_next_state == SHIFT);
      r_dvalid <= w_done;
      r_ovr    <= (r_state == SHIFT) && bus.t_valid;
      if (r_state == IDLE) begin
        if (bus.t_valid) begin
          r_bin <= bus.t_out;
          r_bcd <= '0;
          r_cnt <= '0;
        end
      end else begin
        r_bin <= w_bin_next;
        r_bcd <= w_bcd_next;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_done) r_digits <= w_bcd_next;
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.d_valid = r_dvalid;
  assign bus.ovr     = r_ovr;
  assign bus.digits  = r_digits;

`ifdef TIMER_SEG7_EN
  logic [7*DIGITS-1:0] w_seg;
  logic [7*DIGITS-1:0] r_seg;

  for (genvar d = 0; d < DIGITS; d++) begin : g_seg
    seg7_decode u_seg7 (
      .i_bcd (w_bcd_next[4*d +: 4]),
      .o_seg (w_seg[7*d +: 7])
    );
  end

  // Segments load from the same post-shift value as digits, on the same edge.
  always_ff @(posedge clock) begin
    if (reset)       r_seg <= '0;
    else if (w_done) r_seg <= w_seg;
  end

  assign bus.seg = r_seg;
`endif

endmodule

// File: doc/timer_bcd_decoder.md
Name: timer_bcd_decoder

Overview:
- Consumer end of the timer's t_valid/t_out interface.
- Samples a 16-bit timer count when t_valid is high and converts it to decimal digits for display.
- Conversion is sequential shift-add-3 (double-dabble), one bit per clock.
- Outputs five registered BCD digits plus a one-cycle d_valid strobe; sits between the timer and the board display logic.

Parameters:
- WIDTH, 16, binary input width; must match the timer output width.
- DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- t_valid  input  1  timer count valid.
- t_out  input  WIDTH  timer count value.
- busy  output  1  high while a conversion is in progress.
- d_valid  output  1  one-cycle strobe; digits updated this cycle.
- ovr  output  1  one-cycle strobe; a t_valid sample was dropped because the block was busy.
- digits  output  4*DIGITS  BCD digits; digit 0 (units) in bits [3:0], most significant digit in the top nibble.

Behaviour:
- Reset: synchronous, active-high, takes priority over everything. Clears FSM to IDLE, shift/BCD registers, bit counter, digits, d_valid, ovr and busy to 0. Reset mid-conversion aborts it; no d_valid is produced.
- FSM has two states: IDLE and SHIFT. busy = (state == SHIFT), registered.
- IDLE:
  - On an edge with t_valid=1: load bin_reg <= t_out, bcd_reg <= 0, cnt <= 0, go to SHIFT.
  - With t_valid=0: stay in IDLE.
- SHIFT, each edge:
  - For every BCD nibble >= 5, add 3.
  - Then shift {bcd_reg, bin_reg} left by 1; bin_reg MSB enters bcd_reg bit 0.
  - Increment cnt.
- Completion: on the edge where cnt == WIDTH-1 (the 16th shift):
  - digits <= the final post-shift BCD value.
  - d_valid <= 1 and state <= IDLE.
- Latency: capture at edge E0, shifts at E1..E16. digits and d_valid become valid after E16, i.e. 16 cycles after capture.
- d_valid: high for exactly one cycle; cleared at E17.
- digits: hold their value until the next completion or reset.
- Throughput: the next capture can occur at E17 at the earliest, giving one conversion per 17 cycles.
- t_valid while busy (state == SHIFT): sample ignored; ovr pulses high for one cycle, registered on the same edge. The conversion in progress is unaffected.
- t_valid at E16 (the completion edge): the FSM is still in SHIFT at that edge, so the sample is dropped and ovr pulses.
- Arithmetic:
  - Add-3 is performed on 4-bit nibbles with no carry between nibbles.
  - cnt is $clog2(WIDTH) bits wide.
  - Input value 2^WIDTH - 1 must convert correctly; nibbles never exceed 9 after completion.

Optional Feature:
- Macro: TIMER_SEG7_EN.
- Defined:
  - Adds output seg of width 7*DIGITS, one active-high gfedcba pattern per digit, same nibble ordering as digits.
  - seg is registered on the same edge as digits and is valid together with d_valid; reset value 0 (all segments off).
  - Non-BCD codes are unreachable; their pattern decodes to all-off.
- Not defined: port seg and its logic are absent; all other behaviour is identical.

Decomposition:
- Package timer_pkg holds:
  - the state typedef {IDLE, SHIFT};
  - constants TIMER_WIDTH=16 and TIMER_DIGITS=5;
  - the 7-segment lookup constant table.
- One sub-module, seg7_decode: combinational 4-bit BCD to 7-segment, instantiated DIGITS times under TIMER_SEG7_EN.
- Add-3 correction stays inline as a generate loop; no module for it.

Test Plan:
- t_out=0 with 1-cycle t_valid:
  - 16 cycles later, d_valid pulses for one cycle with digits=0x00000.
  - busy is high for exactly 16 cycles.
- t_out=1234 -> digits=0x01234. t_out=65535 -> digits=0x65535. Both with 16-cycle latency.
- t_valid held high continuously with t_out incrementing from 0:
  - One conversion completes per 17 cycles; ovr pulses on every dropped sample.
  - Each reported value equals the value presented at its capture edge.
- Assert reset at the 8th shift cycle:
  - Next cycle busy=0, digits=0, no d_valid.
  - A new capture of t_out=42 afterwards yields 0x00042.
- With TIMER_SEG7_EN, t_out=8 -> seg digit0 = 7'b1111111, upper digits = 7'b0111111 ('0').
- Without TIMER_SEG7_EN: compiles with no seg port; digit results are identical to the scenarios above.
